// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I+MUL core: opcodes, function fields,
// FSM states and ALU operations.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSN_ECALL = 32'h0000_0073;

  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
  } alu_op_e;

endpackage

// File: rtl/riscv_dmem.sv
// Word-addressed data memory: synchronous write, combinational read.
// Accesses outside the array read as zero and do not write.
module riscv_dmem #(
  parameter int DEPTH = 5300,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [31:0]     addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]   idx;
  logic            in_range;
  logic            unused_lsb;

  assign idx        = addr[AW+1:2];
  assign in_range   = addr[31:2] < 30'(DEPTH);
  assign unused_lsb = ^addr[1:0];
  assign rdata      = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (we && in_range) mem[idx] <= wdata;
  end

endmodule

// File: rtl/riscv_top.sv
// Multi-cycle RV32I+MUL core (FETCH/DECODE/EXEC/MEM/WB) with on-chip instruction
// and data memories; reports completion plus cycle and retired-instruction counts.
module riscv_top
  import riscv_pkg::*;
#(
  parameter int M    = 100,
  parameter int N    = 50,
  parameter int N2   = 2,
  parameter int XLEN = 32
) (
  input  logic        CLOCK_50,
  input  logic        rstn,
  output logic        done,
  output logic [31:0] clock_count,
  output logic [31:0] instr_count
);
  localparam int DMEM_WORDS = M*N + N*N2 + M*N2;

  logic [31:0]     IMem [0:1023];
  logic [XLEN-1:0] Regs [0:31];

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d, ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic            done_q, done_d;
  logic [31:0]     clk_cnt_q, clk_cnt_d, ins_cnt_q, ins_cnt_d;

  logic            rf_we, dm_we, retire, br_taken;
  logic [XLEN-1:0] rf_wdata, dm_rdata, op_b, alu_res;
  logic [31:0]     dm_addr;
  alu_op_e         alu_op;

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'b0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  always_comb begin
    alu_op = ALU_ADD;
    case (f3)
      F3_ADD: begin
        if (opcode == OPC_OP && f7 == F7_MULDIV)  alu_op = ALU_MUL;
        else if (opcode == OPC_OP && f7 == F7_ALT) alu_op = ALU_SUB;
      end
      F3_SLL:  alu_op = ALU_SLL;
      F3_SLT:  alu_op = ALU_SLT;
      F3_SLTU: alu_op = ALU_SLTU;
      F3_XOR:  alu_op = ALU_XOR;
      F3_SR:   alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_op = ALU_OR;
      F3_AND:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  assign op_b = (opcode == OPC_OP) ? b_q : imm_i;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = a_q + op_b;
      ALU_SUB:  alu_res = a_q - op_b;
      ALU_SLL:  alu_res = a_q << op_b[4:0];
      ALU_SLT:  alu_res = XLEN'($signed(a_q) < $signed(op_b));
      ALU_SLTU: alu_res = XLEN'(a_q < op_b);
      ALU_XOR:  alu_res = a_q ^ op_b;
      ALU_SRL:  alu_res = a_q >> op_b[4:0];
      ALU_SRA:  alu_res = $signed(a_q) >>> op_b[4:0];
      ALU_OR:   alu_res = a_q | op_b;
      ALU_AND:  alu_res = a_q & op_b;
      ALU_MUL:  alu_res = a_q * op_b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    case (f3)
      F3_BEQ:  br_taken = (a_q == b_q);
      F3_BNE:  br_taken = (a_q != b_q);
      F3_BLT:  br_taken = ($signed(a_q) < $signed(b_q));
      F3_BGE:  br_taken = !($signed(a_q) < $signed(b_q));
      F3_BLTU: br_taken = (a_q < b_q);
      F3_BGEU: br_taken = !(a_q < b_q);
      default: br_taken = 1'b0;
    endcase
  end

  // Stores address memory in EXEC; loads read in MEM from the address latched in alu_q.
  assign dm_addr = (opcode == OPC_STORE) ? (a_q + imm_s) : alu_q;

  riscv_dmem #(.DEPTH(DMEM_WORDS), .XLEN(XLEN)) D_Memory (
    .clk   (CLOCK_50),
    .we    (dm_we),
    .addr  (dm_addr),
    .wdata (b_q),
    .rdata (dm_rdata)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    done_d   = done_q;
    rf_we    = 1'b0;
    rf_wdata = alu_q;
    dm_we    = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = IMem[pc_q[11:2]];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = Regs[rs1];
        b_d     = Regs[rs2];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OPC_LUI:         begin alu_d = imm_u;          state_d = S_WB;  end
          OPC_AUIPC:       begin alu_d = pc_q + imm_u;   state_d = S_WB;  end
          OPC_IMM, OPC_OP: begin alu_d = alu_res;        state_d = S_WB;  end
          OPC_LOAD:        begin alu_d = a_q + imm_i;    state_d = S_MEM; end
          OPC_STORE: begin
            dm_we = 1'b1; pc_d = pc_q + 32'd4; retire = 1'b1;
          end
          OPC_JAL: begin
            rf_we = 1'b1; rf_wdata = pc_q + 32'd4; pc_d = pc_q + imm_j; retire = 1'b1;
          end
          OPC_JALR: begin
            rf_we = 1'b1; rf_wdata = pc_q + 32'd4;
            pc_d  = (a_q + imm_i) & ~32'd1; retire = 1'b1;
          end
          OPC_BRANCH: begin
            pc_d = br_taken ? (pc_q + imm_b) : (pc_q + 32'd4); retire = 1'b1;
          end
          default: begin
            retire = 1'b1;
            if (ir_q == INSN_ECALL) begin
              done_d  = 1'b1;
              state_d = S_HALT;
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end
        endcase
      end
      S_MEM: begin
        mdr_d   = dm_rdata;
        state_d = S_WB;
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wdata = (opcode == OPC_LOAD) ? mdr_q : alu_q;
        pc_d     = pc_q + 32'd4;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign clk_cnt_d = done_q ? clk_cnt_q : clk_cnt_q + 32'd1;
  assign ins_cnt_d = ins_cnt_q + 32'(retire);

  always_ff @(posedge CLOCK_50) begin
    if (rstn) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      done_q    <= 1'b0;
      clk_cnt_q <= '0;
      ins_cnt_q <= '0;
      for (int unsigned i = 0; i < 32; i++) Regs[i] <= '0;
      Regs[10] <= XLEN'(M);
      Regs[11] <= XLEN'(N);
      Regs[12] <= XLEN'(N2);
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      done_q    <= done_d;
      clk_cnt_q <= clk_cnt_d;
      ins_cnt_q <= ins_cnt_d;
      if (rf_we && rd != 5'd0) Regs[rd] <= rf_wdata;
    end
  end

  assign done        = done_q;
  assign clock_count = clk_cnt_q;
  assign instr_count = ins_cnt_q;

endmodule

// File: tb/tb_riscv_top.sv
// Directed bench for riscv_top: table of single-instruction programs, then
// hand-written programs for load/store, loops, matrix multiply and mid-run reset.
module tb_riscv_top;
  localparam int TM = 4, TN = 3, TN2 = 2;
  localparam int BBASE = TM*TN, CBASE = BBASE + TN*TN2;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [6:0]  OPI = 7'b0010011;

  logic clk = 1'b0, rstn = 1'b1;
  logic done;
  logic [31:0] clock_count, instr_count;
  int tests = 0, fails = 0;

  riscv_top #(.M(TM), .N(TN), .N2(TN2), .XLEN(32)) dut (
    .CLOCK_50(clk), .rstn(rstn), .done(done),
    .clock_count(clock_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] r_t(logic [6:0] f7, int rs2, int rs1, logic [2:0] f3, int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_t(int imm, int rs1, logic [2:0] f3, int rd, logic [6:0] op);
    logic [31:0] t;
    t = imm;
    return {t[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction
  function automatic logic [31:0] s_t(int imm, int rs2, int rs1);
    logic [31:0] t;
    t = imm;
    return {t[11:5], 5'(rs2), 5'(rs1), 3'b010, t[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_t(int off, int rs2, int rs1, logic [2:0] f3);
    logic [31:0] t;
    t = off;
    return {t[12], t[10:5], 5'(rs2), 5'(rs1), f3, t[4:1], t[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] u_t(logic [19:0] imm, int rd, logic [6:0] op);
    return {imm, 5'(rd), op};
  endfunction
  function automatic logic [31:0] j_t(int off, int rd);
    logic [31:0] t;
    t = off;
    return {t[20], t[10:1], t[11], t[19:12], 5'(rd), 7'b1101111};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return i_t(imm, rs1, 3'b000, rd, OPI);
  endfunction
  function automatic logic [31:0] lw(int rd, int rs1, int imm);
    return i_t(imm, rs1, 3'b010, rd, 7'b0000011);
  endfunction

  typedef struct {
    string       name;
    logic [31:0] insn, insn2, a, b;
    int          rd;
    logic [31:0] exp_val;
    int          exp_instr, exp_cyc;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [31:0] insn, logic [31:0] insn2, logic [31:0] a,
                              logic [31:0] b, int rd, logic [31:0] ev, int ei, int ec);
    vec_t v;
    v.name = n; v.insn = insn; v.insn2 = insn2; v.a = a; v.b = b;
    v.rd = rd; v.exp_val = ev; v.exp_instr = ei; v.exp_cyc = ec;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) dut.IMem[i] = ECALL;
  endtask

  task automatic dmem_wr(int idx, logic [31:0] w);
    dut.D_Memory.mem[idx] <= w;
  endtask

  task automatic wait_done(string name, int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk({name, "_done"}, {31'b0, seen}, 32'd1);
  endtask

  int A [TM*TN];
  int B [TN*TN2];
  int C [TM*TN2];
  int ref_cyc;

  task automatic load_matmul_prog();
    clear_prog();
    dut.IMem[0]  = r_t(7'b0000001, 11, 10, 3'b000, 13);
    dut.IMem[1]  = i_t(2, 13, 3'b001, 13, OPI);
    dut.IMem[2]  = r_t(7'b0000001, 12, 11, 3'b000, 15);
    dut.IMem[3]  = i_t(2, 15, 3'b001, 15, OPI);
    dut.IMem[4]  = r_t(7'b0, 15, 13, 3'b000, 14);
    dut.IMem[5]  = addi(16, 0, 0);
    dut.IMem[6]  = addi(17, 0, 0);
    dut.IMem[7]  = addi(18, 0, 0);
    dut.IMem[8]  = addi(19, 0, 0);
    dut.IMem[9]  = r_t(7'b0000001, 11, 16, 3'b000, 20);
    dut.IMem[10] = r_t(7'b0, 18, 20, 3'b000, 20);
    dut.IMem[11] = i_t(2, 20, 3'b001, 20, OPI);
    dut.IMem[12] = lw(21, 20, 0);
    dut.IMem[13] = r_t(7'b0000001, 12, 18, 3'b000, 22);
    dut.IMem[14] = r_t(7'b0, 17, 22, 3'b000, 22);
    dut.IMem[15] = i_t(2, 22, 3'b001, 22, OPI);
    dut.IMem[16] = r_t(7'b0, 13, 22, 3'b000, 22);
    dut.IMem[17] = lw(23, 22, 0);
    dut.IMem[18] = r_t(7'b0000001, 23, 21, 3'b000, 24);
    dut.IMem[19] = r_t(7'b0, 24, 19, 3'b000, 19);
    dut.IMem[20] = addi(18, 18, 1);
    dut.IMem[21] = b_t(-48, 11, 18, 3'b100);
    dut.IMem[22] = r_t(7'b0000001, 12, 16, 3'b000, 25);
    dut.IMem[23] = r_t(7'b0, 17, 25, 3'b000, 25);
    dut.IMem[24] = i_t(2, 25, 3'b001, 25, OPI);
    dut.IMem[25] = r_t(7'b0, 14, 25, 3'b000, 25);
    dut.IMem[26] = s_t(0, 19, 25);
    dut.IMem[27] = addi(17, 17, 1);
    dut.IMem[28] = b_t(-84, 12, 17, 3'b100);
    dut.IMem[29] = addi(16, 16, 1);
    dut.IMem[30] = b_t(-96, 10, 16, 3'b100);
  endtask

  task automatic check_matmul(string tag);
    for (int i = 0; i < TM*TN2; i++)
      chk($sformatf("%s_C%0d", tag, i), dut.D_Memory.mem[CBASE+i], C[i]);
    chk({tag, "_instr"}, instr_count, 32'd403);
  endtask

  initial begin
    vecs.push_back(mk("add",   r_t(7'b0000000, 6, 5, 3'b000, 7), ECALL, 7, -3, 7, 4, 4, 17));
    vecs.push_back(mk("sub",   r_t(7'b0100000, 6, 5, 3'b000, 7), ECALL, 7, -3, 7, 10, 4, 17));
    vecs.push_back(mk("mul",   r_t(7'b0000001, 6, 5, 3'b000, 7), ECALL, 7, -3, 7, 32'hFFFF_FFEB, 4, 17));
    vecs.push_back(mk("mulwr", r_t(7'b0000001, 6, 5, 3'b000, 7), ECALL, 32'h10000, 32'h10000, 7, 0, 4, 17));
    vecs.push_back(mk("slt",   r_t(7'b0000000, 6, 5, 3'b010, 7), ECALL, -1, 1, 7, 1, 4, 17));
    vecs.push_back(mk("sltu",  r_t(7'b0000000, 6, 5, 3'b011, 7), ECALL, -1, 1, 7, 0, 4, 17));
    vecs.push_back(mk("sll",   r_t(7'b0000000, 6, 5, 3'b001, 7), ECALL, 1, 33, 7, 2, 4, 17));
    vecs.push_back(mk("sra",   r_t(7'b0100000, 6, 5, 3'b101, 7), ECALL, 32'h8000_0000, 4, 7, 32'hF800_0000, 4, 17));
    vecs.push_back(mk("srl",   r_t(7'b0000000, 6, 5, 3'b101, 7), ECALL, 32'h8000_0000, 4, 7, 32'h0800_0000, 4, 17));
    vecs.push_back(mk("xor",   r_t(7'b0000000, 6, 5, 3'b100, 7), ECALL, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 7, 32'hFF00_FF00, 4, 17));
    vecs.push_back(mk("or",    r_t(7'b0000000, 6, 5, 3'b110, 7), ECALL, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 7, 32'hFFF0_FFF0, 4, 17));
    vecs.push_back(mk("and",   r_t(7'b0000000, 6, 5, 3'b111, 7), ECALL, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 7, 32'h00F0_00F0, 4, 17));
    vecs.push_back(mk("addi",  addi(7, 5, -1), ECALL, 0, 0, 7, 32'hFFFF_FFFF, 4, 17));
    vecs.push_back(mk("srai",  i_t(32'h41F, 5, 3'b101, 7, OPI), ECALL, 32'h8000_0000, 0, 7, 32'hFFFF_FFFF, 4, 17));
    vecs.push_back(mk("sltiu", i_t(-1, 5, 3'b011, 7, OPI), ECALL, 5, 0, 7, 1, 4, 17));
    vecs.push_back(mk("lui",   u_t(20'hABCDE, 7, 7'b0110111), ECALL, 0, 0, 7, 32'hABCD_E000, 4, 17));
    vecs.push_back(mk("auipc", u_t(20'h00001, 7, 7'b0010111), ECALL, 0, 0, 7, 32'h0000_1008, 4, 17));
    vecs.push_back(mk("x0wr",  r_t(7'b0000000, 6, 5, 3'b000, 0), ECALL, 7, -3, 0, 0, 4, 17));
    vecs.push_back(mk("beq_t", b_t(8, 6, 5, 3'b000), addi(7, 0, 1), 5, 5, 7, 0, 4, 16));
    vecs.push_back(mk("bne_n", b_t(8, 6, 5, 3'b001), addi(7, 0, 1), 5, 5, 7, 1, 5, 20));
    vecs.push_back(mk("blt_t", b_t(8, 6, 5, 3'b100), addi(7, 0, 1), -1, 1, 7, 0, 4, 16));
    vecs.push_back(mk("bge_n", b_t(8, 6, 5, 3'b101), addi(7, 0, 1), -1, 1, 7, 1, 5, 20));
    vecs.push_back(mk("bltu_n", b_t(8, 6, 5, 3'b110), addi(7, 0, 1), -1, 1, 7, 1, 5, 20));
    vecs.push_back(mk("jal",   j_t(8, 7), addi(7, 0, 1), 0, 0, 7, 12, 4, 16));

    // Reset state, then "addi x5,x0,7; addi x6,x0,-3; mul x7,x5,x6; ecall".
    hold_reset();
    clear_prog();
    dut.IMem[0] = addi(5, 0, 7);
    dut.IMem[1] = addi(6, 0, -3);
    dut.IMem[2] = r_t(7'b0000001, 6, 5, 3'b000, 7);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_clk", clock_count, 0);
    chk("rst_instr", instr_count, 0);
    chk("rst_pc", dut.pc_q, 0);
    chk("rst_x10", dut.Regs[10], TM);
    chk("rst_x11", dut.Regs[11], TN);
    chk("rst_x12", dut.Regs[12], TN2);
    chk("rst_x5", dut.Regs[5], 0);
    release_reset();
    repeat (3) @(negedge clk);
    chk("early_clk", clock_count, 3);
    wait_done("mulprog", 200);
    chk("mulprog_x7", dut.Regs[7], 32'hFFFF_FFEB);
    chk("mulprog_instr", instr_count, 4);
    chk("mulprog_clk", clock_count, 15);
    repeat (6) @(negedge clk);
    chk("halt_clk", clock_count, 15);
    chk("halt_instr", instr_count, 4);
    chk("halt_pc", dut.pc_q, 12);
    chk("halt_done", {31'b0, done}, 1);

    foreach (vecs[t]) begin
      hold_reset();
      clear_prog();
      dut.IMem[0] = lw(5, 0, 0);
      dut.IMem[1] = lw(6, 0, 4);
      dut.IMem[2] = vecs[t].insn;
      dut.IMem[3] = vecs[t].insn2;
      dmem_wr(0, vecs[t].a);
      dmem_wr(1, vecs[t].b);
      release_reset();
      wait_done(vecs[t].name, 200);
      chk({vecs[t].name, "_rd"}, dut.Regs[vecs[t].rd], vecs[t].exp_val);
      chk({vecs[t].name, "_instr"}, instr_count, vecs[t].exp_instr);
      chk({vecs[t].name, "_clk"}, clock_count, vecs[t].exp_cyc);
    end

    // Store then load through the same address; LW must take five cycles.
    hold_reset();
    clear_prog();
    dut.IMem[0] = addi(7, 0, -21);
    dut.IMem[1] = s_t(8, 7, 0);
    dut.IMem[2] = lw(8, 0, 8);
    dmem_wr(2, 32'h1234_5678);
    release_reset();
    wait_done("swlw", 200);
    chk("swlw_mem2", dut.D_Memory.mem[2], 32'hFFFF_FFEB);
    chk("swlw_x8", dut.Regs[8], 32'hFFFF_FFEB);
    chk("swlw_instr", instr_count, 4);
    chk("swlw_clk", clock_count, 15);

    // Ten-iteration addi/bne loop.
    hold_reset();
    clear_prog();
    dut.IMem[0] = addi(5, 0, 0);
    dut.IMem[1] = addi(6, 0, 10);
    dut.IMem[2] = addi(5, 5, 1);
    dut.IMem[3] = b_t(-4, 6, 5, 3'b001);
    release_reset();
    wait_done("loop", 500);
    chk("loop_x5", dut.Regs[5], 10);
    chk("loop_instr", instr_count, 23);
    chk("loop_clk", clock_count, 81);

    // Matrix multiply on random signed data.
    hold_reset();
    load_matmul_prog();
    foreach (A[i]) begin A[i] = int'($urandom_range(0, 2000)) - 1000; dmem_wr(i, A[i]); end
    foreach (B[i]) begin B[i] = int'($urandom_range(0, 2000)) - 1000; dmem_wr(BBASE + i, B[i]); end
    for (int i = 0; i < TM; i++)
      for (int j = 0; j < TN2; j++) begin
        C[i*TN2+j] = 0;
        for (int k = 0; k < TN; k++) C[i*TN2+j] += A[i*TN+k] * B[k*TN2+j];
        dmem_wr(CBASE + i*TN2 + j, 32'hDEAD_BEEF);
      end
    release_reset();
    wait_done("mm", 20000);
    check_matmul("mm");
    ref_cyc = clock_count;

    // Reset mid-run: counters clear, and the restart reproduces the same result.
    hold_reset();
    load_matmul_prog();
    release_reset();
    repeat (300) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_done", {31'b0, done}, 0);
    chk("mid_clk", clock_count, 0);
    chk("mid_instr", instr_count, 0);
    chk("mid_pc", dut.pc_q, 0);
    for (int i = 0; i < TM*TN2; i++) dmem_wr(CBASE + i, 32'hDEAD_BEEF);
    release_reset();
    wait_done("mm2", 20000);
    check_matmul("mm2");
    chk("mm2_clk", clock_count, ref_cyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
